// File: rtl/poolb_ctrl_u3_pkg.sv
// poolb_pkg: shared helpers, default derived sizes and FSM states for the pooling sequencer
package poolb_pkg;

    // Ceiling log2, floored at 1 so degenerate sizes still yield a usable port width
    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DEF_IFM_SIZE   = 7;
    localparam int DEF_IFM_DEPTH  = 16;
    localparam int DEF_NUM_UNITS  = 3;
    localparam int DEF_OFM_SIZE   = DEF_IFM_SIZE / 2;
    localparam int DEF_NUM_GROUPS = (DEF_IFM_DEPTH + DEF_NUM_UNITS - 1) / DEF_NUM_UNITS;
    localparam int DEF_IFM_AW     = clog2(DEF_IFM_SIZE * DEF_IFM_SIZE);
    localparam int DEF_OFM_AW     = clog2(DEF_OFM_SIZE * DEF_OFM_SIZE);
    localparam int DEF_GRP_W      = clog2(DEF_NUM_GROUPS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

endpackage

// File: rtl/poolb_ctrl_u3_if.sv
// poolb_ctrl_u3_if: control, IFM read and OFM write signals of the pooling sequencer
interface poolb_ctrl_u3_if
    import poolb_pkg::*;
#(
    parameter int IFM_AW    = DEF_IFM_AW,
    parameter int OFM_AW    = DEF_OFM_AW,
    parameter int GRP_W     = DEF_GRP_W,
    parameter int NUM_UNITS = DEF_NUM_UNITS
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 ram_rd_en;
    logic [IFM_AW-1:0]    ram_addr_A;
    logic [IFM_AW-1:0]    ram_addr_B;
    logic [GRP_W-1:0]     rd_group;
    logic                 fifo_enable;
    logic                 pool_enable;
    logic                 ofm_wr_en;
    logic [OFM_AW-1:0]    ofm_addr;
    logic [GRP_W-1:0]     ofm_group;
    logic [NUM_UNITS-1:0] unit_mask;

    modport master (
        input  start,
        output busy, done, ram_rd_en, ram_addr_A, ram_addr_B, rd_group,
               fifo_enable, pool_enable, ofm_wr_en, ofm_addr, ofm_group, unit_mask
    );

    modport slave (
        output start,
        input  busy, done, ram_rd_en, ram_addr_A, ram_addr_B, rd_group,
               fifo_enable, pool_enable, ofm_wr_en, ofm_addr, ofm_group, unit_mask
    );
endinterface

// File: rtl/poolb_ctrl_u3_delay.sv
// poolb_ctrl_delay: DEPTH-stage shift register that carries strobes and their fields
module poolb_ctrl_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    // shift one stage per cycle; reset empties every stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/poolb_ctrl_u3.sv
// poolb_ctrl_u3: row-pair/column sequencer driving IFM reads, pool strobes and OFM writes
module poolb_ctrl_u3
    import poolb_pkg::*;
#(
    parameter int IFM_SIZE     = 7,
    parameter int IFM_DEPTH    = 16,
    parameter int KERNAL_SIZE  = 2,
    parameter int NUM_UNITS    = 3,
    parameter int RAM_LATENCY  = 1,
    parameter int POOL_LATENCY = 1
) (
    input logic             clk,
    input logic             reset,
    poolb_ctrl_u3_if.master bus
);
    localparam int OFM_SIZE   = IFM_SIZE / KERNAL_SIZE;
    localparam int COLS       = KERNAL_SIZE * OFM_SIZE;
    localparam int NUM_GROUPS = (IFM_DEPTH + NUM_UNITS - 1) / NUM_UNITS;
    localparam int IFM_AW     = clog2(IFM_SIZE * IFM_SIZE);
    localparam int OFM_AW     = clog2(OFM_SIZE * OFM_SIZE);
    localparam int GRP_W      = clog2(NUM_GROUPS);
    localparam int CW         = clog2(COLS);
    localparam int RW         = clog2(OFM_SIZE);

    typedef struct packed {
        logic             v;
        logic             odd;
        logic [RW-1:0]    ocol;
        logic [RW-1:0]    orow;
        logic [GRP_W-1:0] grp;
    } rd_t;

    typedef struct packed {
        logic              v;
        logic [OFM_AW-1:0] addr;
        logic [GRP_W-1:0]  grp;
    } wr_t;

    state_t            state, state_nx;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [GRP_W-1:0]  grp;
    logic              issue, col_last, row_last, grp_last, last_wr, pool_en;
    logic [IFM_AW-1:0] addr_a;
    rd_t               rd_in, rd_out;
    wr_t               wr_in, wr_out;

    assign issue    = state == RUN;
    assign col_last = col == CW'(COLS - 1);
    assign row_last = row == RW'(OFM_SIZE - 1);
    assign grp_last = grp == GRP_W'(NUM_GROUPS - 1);
    assign addr_a   = IFM_AW'(row) * IFM_AW'(2 * IFM_SIZE) + IFM_AW'(col);

    // fields are zeroed when idle so the delay lines only ever hold live entries
    assign rd_in   = issue ? rd_t'{1'b1, col[0], RW'(col >> 1), row, grp} : '0;
    assign pool_en = rd_out.v & rd_out.odd;
    assign wr_in   = pool_en ? wr_t'{1'b1, OFM_AW'(rd_out.orow) * OFM_AW'(OFM_SIZE) + OFM_AW'(rd_out.ocol), rd_out.grp} : '0;
    assign last_wr = wr_out.v && wr_out.addr == OFM_AW'(OFM_SIZE * OFM_SIZE - 1) && wr_out.grp == GRP_W'(NUM_GROUPS - 1);

    poolb_ctrl_delay #(.DEPTH(RAM_LATENCY), .WIDTH($bits(rd_t))) u_rd_dly (
        .clk(clk), .reset(reset), .din(rd_in), .dout(rd_out)
    );

    poolb_ctrl_delay #(.DEPTH(POOL_LATENCY), .WIDTH($bits(wr_t))) u_wr_dly (
        .clk(clk), .reset(reset), .din(wr_in), .dout(wr_out)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // column walks fastest, then row pair, then channel group; all wrap to zero at the end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
            grp <= '0;
        end else if (issue) begin
            col <= col_last ? '0 : col + 1'b1;
            if (col_last) row <= row_last ? '0 : row + 1'b1;
            if (col_last && row_last) grp <= grp_last ? '0 : grp + 1'b1;
        end
    end

    // next state and status; start only matters in IDLE
    always_comb begin
        state_nx = state == IDLE  ? (bus.start ? RUN : IDLE) :
                   state == RUN   ? (col_last && row_last && grp_last ? DRAIN : RUN) :
                   state == DRAIN ? (last_wr ? DONE : DRAIN) : IDLE;
        bus.busy = state == RUN || state == DRAIN;
        bus.done = state == DONE;
    end

    // a unit is enabled only if its channel exists in the written group
    always_comb begin
        bus.unit_mask = '0;
        for (int u = 0; u < NUM_UNITS; u++)
            bus.unit_mask[u] = wr_out.v && (int'(wr_out.grp) * NUM_UNITS + u < IFM_DEPTH);
    end

    assign bus.ram_rd_en   = issue;
    assign bus.ram_addr_A  = issue ? addr_a : '0;
    assign bus.ram_addr_B  = issue ? addr_a + IFM_AW'(IFM_SIZE) : '0;
    assign bus.rd_group    = issue ? grp : '0;
    assign bus.fifo_enable = rd_out.v;
    assign bus.pool_enable = pool_en;
    assign bus.ofm_wr_en   = wr_out.v;
    assign bus.ofm_addr    = wr_out.addr;
    assign bus.ofm_group   = wr_out.grp;
endmodule

// File: tb/tb_poolb_ctrl_u3.sv
// tb_poolb_ctrl_u3: three parameterisations checked every cycle against an arithmetic schedule model
module tb_poolb_ctrl_u3;
    typedef struct packed {
        logic        busy, done, rd, fe, pe, wr;
        logic [15:0] a, b;
        logic [7:0]  rg;
        logic [15:0] oa;
        logic [7:0]  og, mask;
    } obs_t;

    typedef struct {
        int t, rd, a, b, wr, oa, done;
    } vec_t;

    logic clk = 0, reset = 0, start = 0;
    int   cyc = 0, n_vec = 0, n_bad = 0;
    int   isz[3] = '{7, 7, 4};
    int   dep[3] = '{16, 16, 3};
    int   rl[3]  = '{1, 3, 1};
    int   pl[3]  = '{1, 2, 1};
    int   s[3], dd[3];
    bit   act[3];
    obs_t o[3];
    vec_t tbl[14];

    poolb_ctrl_u3_if #(.IFM_AW(6), .OFM_AW(4), .GRP_W(3), .NUM_UNITS(3)) bus0 ();
    poolb_ctrl_u3_if #(.IFM_AW(6), .OFM_AW(4), .GRP_W(3), .NUM_UNITS(3)) bus1 ();
    poolb_ctrl_u3_if #(.IFM_AW(4), .OFM_AW(2), .GRP_W(1), .NUM_UNITS(3)) bus2 ();

    assign bus0.start = start;
    assign bus1.start = start;
    assign bus2.start = start;

    poolb_ctrl_u3 #(.IFM_SIZE(7), .IFM_DEPTH(16), .KERNAL_SIZE(2), .NUM_UNITS(3), .RAM_LATENCY(1), .POOL_LATENCY(1))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    poolb_ctrl_u3 #(.IFM_SIZE(7), .IFM_DEPTH(16), .KERNAL_SIZE(2), .NUM_UNITS(3), .RAM_LATENCY(3), .POOL_LATENCY(2))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    poolb_ctrl_u3 #(.IFM_SIZE(4), .IFM_DEPTH(3), .KERNAL_SIZE(2), .NUM_UNITS(3), .RAM_LATENCY(1), .POOL_LATENCY(1))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    function automatic int dur(input int i);
        int osz = isz[i] / 2;
        return ((dep[i] + 2) / 3) * osz * 2 * osz + rl[i] + pl[i] + 1;
    endfunction

    // expected outputs t cycles after the accepted start edge (t=1 is the first issue)
    function automatic obs_t exp_out(input int i, input int t);
        int   osz  = isz[i] / 2;
        int   cols = 2 * osz;
        int   per  = osz * cols;
        int   n    = ((dep[i] + 2) / 3) * per;
        int   d    = n + rl[i] + pl[i] + 1;
        int   k;
        obs_t e    = '0;
        if (t < 1 || t > d) return e;
        e.busy = t < d;
        e.done = t == d;
        k = t - 1;
        if (k < n) begin
            e.rd = 1;
            e.a  = 16'(2 * ((k % per) / cols) * isz[i] + k % cols);
            e.b  = e.a + 16'(isz[i]);
            e.rg = 8'(k / per);
        end
        k = t - 1 - rl[i];
        if (k >= 0 && k < n) begin
            e.fe = 1;
            e.pe = (k % cols) % 2 == 1;
        end
        k = t - 1 - rl[i] - pl[i];
        if (k >= 0 && k < n && (k % cols) % 2 == 1) begin
            e.wr = 1;
            e.oa = 16'(((k % per) / cols) * osz + (k % cols) / 2);
            e.og = 8'(k / per);
            for (int u = 0; u < 3; u++) e.mask[u] = (k / per) * 3 + u < dep[i];
        end
        return e;
    endfunction

    function automatic obs_t cap(input logic bz, dn, rd, fe, pe, wr, input logic [15:0] a, b,
                                 input logic [7:0] rg, input logic [15:0] oa, input logic [7:0] og, mask);
        return {bz, dn, rd, fe, pe, wr, a, b, rg, oa, og, mask};
    endfunction

    task automatic check_all();
        obs_t e;
        o[0] = cap(bus0.busy, bus0.done, bus0.ram_rd_en, bus0.fifo_enable, bus0.pool_enable, bus0.ofm_wr_en,
                   16'(bus0.ram_addr_A), 16'(bus0.ram_addr_B), 8'(bus0.rd_group), 16'(bus0.ofm_addr),
                   8'(bus0.ofm_group), 8'(bus0.unit_mask));
        o[1] = cap(bus1.busy, bus1.done, bus1.ram_rd_en, bus1.fifo_enable, bus1.pool_enable, bus1.ofm_wr_en,
                   16'(bus1.ram_addr_A), 16'(bus1.ram_addr_B), 8'(bus1.rd_group), 16'(bus1.ofm_addr),
                   8'(bus1.ofm_group), 8'(bus1.unit_mask));
        o[2] = cap(bus2.busy, bus2.done, bus2.ram_rd_en, bus2.fifo_enable, bus2.pool_enable, bus2.ofm_wr_en,
                   16'(bus2.ram_addr_A), 16'(bus2.ram_addr_B), 8'(bus2.rd_group), 16'(bus2.ofm_addr),
                   8'(bus2.ofm_group), 8'(bus2.unit_mask));
        for (int i = 0; i < 3; i++) begin
            e = exp_out(i, act[i] ? cyc - s[i] + 1 : 0);
            n_vec++;
            if (o[i] !== e) begin
                n_bad++;
                $display("FAIL dut%0d cycle %0d: got %h expected %h", i, cyc, o[i], e);
            end
        end
    endtask

    // one clock: the model accepts start where an idle sequencer would, then outputs are checked
    task automatic step();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++)
            if (reset && start && (!act[i] || cyc - s[i] > dd[i])) begin
                act[i] = 1;
                s[i]   = cyc;
            end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int n);
        reset = 0;
        for (int i = 0; i < 3; i++) act[i] = 0;
        #1;
        check_all();
        repeat (n) step();
        reset = 1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) dd[i] = dur(i);
        tbl[0]  = '{1,   1, 0,  7,  0, 0, 0};
        tbl[1]  = '{2,   1, 1,  8,  0, 0, 0};
        tbl[2]  = '{4,   1, 3,  10, 1, 0, 0};
        tbl[3]  = '{6,   1, 5,  12, 1, 1, 0};
        tbl[4]  = '{7,   1, 14, 21, 0, 0, 0};
        tbl[5]  = '{8,   1, 15, 22, 1, 2, 0};
        tbl[6]  = '{20,  1, 1,  8,  1, 8, 0};
        tbl[7]  = '{22,  1, 3,  10, 1, 0, 0};
        tbl[8]  = '{108, 1, 33, 40, 1, 7, 0};
        tbl[9]  = '{109, 0, 0,  0,  0, 0, 0};
        tbl[10] = '{110, 0, 0,  0,  1, 8, 0};
        tbl[11] = '{111, 0, 0,  0,  0, 0, 1};
        tbl[12] = '{112, 0, 0,  0,  0, 0, 0};
        tbl[13] = '{113, 1, 0,  7,  0, 0, 0};
        do_reset(3);
        repeat (2) step();
        start = 1;
        step();
        start = 0;
        for (int t = 1; t <= 113; t++) begin
            for (int j = 0; j < 14; j++)
                if (tbl[j].t == t) begin
                    n_vec++;
                    if (int'(o[0].rd) != tbl[j].rd || int'(o[0].a) != tbl[j].a || int'(o[0].b) != tbl[j].b ||
                        int'(o[0].wr) != tbl[j].wr || int'(o[0].oa) != tbl[j].oa || int'(o[0].done) != tbl[j].done) begin
                        n_bad++;
                        $display("FAIL vec t=%0d: got rd=%0d A=%0d B=%0d wr=%0d oa=%0d done=%0d expected rd=%0d A=%0d B=%0d wr=%0d oa=%0d done=%0d",
                                 t, o[0].rd, o[0].a, o[0].b, o[0].wr, o[0].oa, o[0].done,
                                 tbl[j].rd, tbl[j].a, tbl[j].b, tbl[j].wr, tbl[j].oa, tbl[j].done);
                    end
                end
            start = t == 20 || t == 111 || t == 112;
            step();
        end
        start = 0;
        repeat (48) step();
        do_reset(2);
        repeat (5) step();
        start = 1;
        step();
        start = 0;
        repeat (120) step();
        for (int n = 0; n < 4000; n++) begin
            start = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
            else step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/poolb_ctrl_u3.md
# poolb_ctrl_u3

Sequencer for the three-unit max/avg pooling datapath (`poolb_dp_U3`), in the same pooling stage.
- Walks the input feature map in row pairs and columns, issuing paired row read addresses (rows A/B) to the IFM buffer.
- Generates the `fifo_enable`/`pool_enable` strobes aligned to returning data.
- Produces OFM write enable, address and channel group aligned to the pooled outputs.
- Processes channels in groups of NUM_UNITS, one channel per pooling unit.

## Interface
Parameters:
- IFM_SIZE, 7: input map width/height; odd trailing row/column is discarded.
- IFM_DEPTH, 16: input channels.
- KERNAL_SIZE, 2: pooling window and stride; only 2 is supported.
- NUM_UNITS, 3: parallel pooling units.
- RAM_LATENCY, 1: cycles from read address to data at the unit inputs (≥1).
- POOL_LATENCY, 1: cycles from `pool_enable` to valid `data_out_*` (≥1).

Derived:
- OFM_SIZE = IFM_SIZE/2
- NUM_GROUPS = ceil(IFM_DEPTH/NUM_UNITS)
- IFM_AW = clog2(IFM_SIZE²)
- OFM_AW = clog2(OFM_SIZE²)
- GRP_W = clog2(NUM_GROUPS)

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to pool the whole map.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the final OFM write.
- ram_rd_en  out  1  read issue strobe.
- ram_addr_A  out  IFM_AW  even-row address, row*IFM_SIZE+col.
- ram_addr_B  out  IFM_AW  odd-row address, ram_addr_A+IFM_SIZE.
- rd_group  out  GRP_W  channel group being read.
- fifo_enable  out  1  column data valid at unit inputs.
- pool_enable  out  1  2x2 window complete at unit inputs.
- ofm_wr_en  out  1  pooled outputs valid.
- ofm_addr  out  OFM_AW  orow*OFM_SIZE+ocol.
- ofm_group  out  GRP_W  channel group of the write.
- unit_mask  out  NUM_UNITS  bit u high if channel group*NUM_UNITS+u < IFM_DEPTH; aligned to ofm_wr_en.

Reset value: every output is 0.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → RUN. start in any other state is ignored.
- RUN issues one column per cycle, no stalls.
  - Loop order: group (outer), row pair r in 0..OFM_SIZE-1, col c in 0..2*OFM_SIZE-1 (inner).
  - ram_addr_A = 2r*IFM_SIZE+c.
  - Row 2*OFM_SIZE and column 2*OFM_SIZE, when present, are never read.
- After the last issue (final group, r=OFM_SIZE-1, c=2*OFM_SIZE-1) → DRAIN.
- DRAIN lasts until the last ofm_wr_en, then → DONE.
- DONE: done=1 and busy=0 for one cycle, then → IDLE.
- Row pairs and groups follow back-to-back with no bubble.
- pool_enable is asserted only together with fifo_enable for odd c.
- OFM address ocol = c/2.
- Counters wrap: c to 0 increments r; r to 0 increments group.
- Reset asserted mid-operation: FSM → IDLE; counters and delay lines clear immediately; no further strobes. A partial map is abandoned.

## Timing
- start sampled at edge 0 → issue k (k=0..N-1, N = NUM_GROUPS*OFM_SIZE*2*OFM_SIZE) at cycle 1+k.
- fifo_enable(k) at cycle 1+k+RAM_LATENCY.
- ofm_wr_en for odd-c issue k at cycle 1+k+RAM_LATENCY+POOL_LATENCY.
- done at the cycle after the last write: N+RAM_LATENCY+POOL_LATENCY+1.
- Defaults: N=108, done at cycle 111, 54 writes.
- rd_group changes on the same cycle as the first address of a new group.
- ofm_group and unit_mask change on the same cycle as that group's first write.

## Structure
- Package poolb_pkg:
  - clog2 function.
  - Derived constants OFM_SIZE, NUM_GROUPS, address widths.
  - FSM state enum.
- Sub-module poolb_ctrl_delay: parameterised DEPTH×WIDTH shift register, reset to 0. Instantiated twice:
  - RAM_LATENCY, carrying {valid, odd, ocol, orow, group}.
  - POOL_LATENCY, carrying the write fields.

## Test plan
- Default params, start at edge 0:
  - 108 ram_rd_en cycles 1..108.
  - First addresses A=0, B=7; issue 6 gives A=14, B=21.
  - 54 ofm_wr_en, ofm_addr cycling 0..8 per group.
  - done only at cycle 111.
- Strobe alignment: fifo_enable exactly 1 cycle after each rd_en; pool_enable on every second fifo_enable; ofm_wr_en 1 cycle after each pool_enable. With RAM_LATENCY=3, POOL_LATENCY=2, done at cycle 114.
- Last group (6): unit_mask=3'b001 on its writes; all earlier groups 3'b111. Address 6, 13 and 42..48 never issued.
- start pulsed at cycles 20 and 111 (busy/DONE) ignored: exactly one done, no restart. start at cycle 112 (IDLE) begins a new pass with first issue at 113.
- reset low at cycle 50 for 2 cycles: all outputs 0 immediately, no strobes until the next start. A following full run matches the first scenario.
- IFM_SIZE=4, IFM_DEPTH=3: 8 issues, 4 writes, ofm_addr 0..3, done at cycle 11.
